// File: rtl/wb_pkg.sv
// Shared definitions for the writeback arbiter: default widths, source indices
// and a small modulo-3 increment helper used by the round-robin picker.
// No ports; imported by wb_arb_pick and wb_arbiter.
package wb_pkg;

   localparam int DATA_W_DEF = 16;
   localparam int REG_W_DEF  = 3;
   localparam int NUM_SRC    = 3;

   typedef logic [1:0] src_idx_t;

   localparam src_idx_t SRC_ALU = 2'd0;
   localparam src_idx_t SRC_MUL = 2'd1;
   localparam src_idx_t SRC_MEM = 2'd2;

   // Next source index, wrapping 2 -> 0 (index 3 is never produced).
   function automatic src_idx_t wrap_inc(input src_idx_t i);
      return (i == SRC_MEM) ? SRC_ALU : src_idx_t'(i + 2'd1);
   endfunction

endpackage

// File: rtl/wb_arb_pick.sv
// Combinational 3-way grant picker over the holding-entry occupancy.
// Ports: occ (entry occupied), ptr (round-robin start index) in;
//        gnt_oh (one-hot grant), gnt_idx (granted index), gnt_any out.
// Macro WB_ROUND_ROBIN_EN selects round-robin from ptr; otherwise fixed
// priority MEM > ALU > MUL and ptr is ignored.
module wb_arb_pick
   import wb_pkg::*;
(
   input  logic [2:0] occ,
   input  src_idx_t   ptr,
   output logic [2:0] gnt_oh,
   output src_idx_t   gnt_idx,
   output logic       gnt_any
);

   assign gnt_any = |occ;

`ifdef WB_ROUND_ROBIN_EN
   src_idx_t cand;
   logic     found;

   // Walk the three indices starting at ptr; the first occupied one wins.
   always_comb begin
      gnt_oh  = '0;
      gnt_idx = SRC_ALU;
      found   = 1'b0;
      cand    = ptr;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (!found && occ[cand]) begin
            gnt_oh[cand] = 1'b1;
            gnt_idx      = cand;
            found        = 1'b1;
         end
         cand = wrap_inc(cand);
      end
   end
`else
   logic unused_ptr;
   assign unused_ptr = ^ptr;

   always_comb begin
      gnt_oh  = '0;
      gnt_idx = SRC_ALU;
      if (occ[SRC_MEM]) begin
         gnt_oh[SRC_MEM] = 1'b1;
         gnt_idx         = SRC_MEM;
      end else if (occ[SRC_ALU]) begin
         gnt_oh[SRC_ALU] = 1'b1;
         gnt_idx         = SRC_ALU;
      end else if (occ[SRC_MUL]) begin
         gnt_oh[SRC_MUL] = 1'b1;
         gnt_idx         = SRC_MUL;
      end
   end
`endif

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: three result sources (s0 ALU, s1 MUL, s2 MEM) each with
// one holding entry, arbitrated onto a single register-file write port.
// Ports: clock, reset (sync, active-high), flush; per source valid/data/dest
// in and ready out; wb_en/wb_dest/wb_data/wb_sel registered out.
// Latency: accept on edge k, writeback visible after edge k+1 at the earliest.
// Macro WB_ROUND_ROBIN_EN: round-robin grant with a start pointer register;
// undefined: fixed priority s2 > s0 > s1.
module wb_arbiter
   import wb_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int REG_W  = REG_W_DEF
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              flush,
   input  logic              s0_valid,
   input  logic [DATA_W-1:0] s0_data,
   input  logic [REG_W-1:0]  s0_dest,
   output logic              s0_ready,
   input  logic              s1_valid,
   input  logic [DATA_W-1:0] s1_data,
   input  logic [REG_W-1:0]  s1_dest,
   output logic              s1_ready,
   input  logic              s2_valid,
   input  logic [DATA_W-1:0] s2_data,
   input  logic [REG_W-1:0]  s2_dest,
   output logic              s2_ready,
   output logic              wb_en,
   output logic [REG_W-1:0]  wb_dest,
   output logic [DATA_W-1:0] wb_data,
   output logic [1:0]        wb_sel
);

   logic [2:0]        in_vld;
   logic [DATA_W-1:0] in_dat [NUM_SRC];
   logic [REG_W-1:0]  in_dst [NUM_SRC];

   assign in_vld    = {s2_valid, s1_valid, s0_valid};
   assign in_dat[0] = s0_data;
   assign in_dat[1] = s1_data;
   assign in_dat[2] = s2_data;
   assign in_dst[0] = s0_dest;
   assign in_dst[1] = s1_dest;
   assign in_dst[2] = s2_dest;

   // Holding entries.
   logic [2:0]        vld_q, vld_d;
   logic [DATA_W-1:0] dat_q [NUM_SRC];
   logic [DATA_W-1:0] dat_d [NUM_SRC];
   logic [REG_W-1:0]  dst_q [NUM_SRC];
   logic [REG_W-1:0]  dst_d [NUM_SRC];

   // Registered writeback port.
   logic              wb_en_q, wb_en_d;
   logic [REG_W-1:0]  wb_dest_q, wb_dest_d;
   logic [DATA_W-1:0] wb_data_q, wb_data_d;
   src_idx_t          wb_sel_q, wb_sel_d;

   src_idx_t   ptr;
   logic [2:0] gnt_oh;
   src_idx_t   gnt_idx;
   logic       gnt_any;
   logic [2:0] rdy;

`ifdef WB_ROUND_ROBIN_EN
   // ptr_q holds the search start, i.e. (last granted + 1) mod 3.
   src_idx_t ptr_q, ptr_d;
   assign ptr = ptr_q;

   always_comb begin
      ptr_d = ptr_q;
      if (!flush && gnt_any) begin
         ptr_d = wrap_inc(gnt_idx);
      end
   end
`else
   assign ptr = SRC_ALU;
`endif

   wb_arb_pick u_pick (
      .occ     (vld_q),
      .ptr     (ptr),
      .gnt_oh  (gnt_oh),
      .gnt_idx (gnt_idx),
      .gnt_any (gnt_any)
   );

   // Ready never looks at any valid input, so there is no valid->ready path.
   assign rdy      = (~vld_q | gnt_oh) & {3{~flush & ~reset}};
   assign s0_ready = rdy[0];
   assign s1_ready = rdy[1];
   assign s2_ready = rdy[2];

   always_comb begin
      vld_d     = vld_q;
      dat_d     = dat_q;
      dst_d     = dst_q;
      wb_en_d   = 1'b0;
      wb_dest_d = wb_dest_q;
      wb_data_d = wb_data_q;
      wb_sel_d  = wb_sel_q;
      if (flush) begin
         vld_d = '0;
      end else begin
         for (int n = 0; n < NUM_SRC; n++) begin
            // A refill on the grant edge wins over the clear.
            if (in_vld[n] && rdy[n]) begin
               vld_d[n] = 1'b1;
               dat_d[n] = in_dat[n];
               dst_d[n] = in_dst[n];
            end else if (gnt_oh[n]) begin
               vld_d[n] = 1'b0;
            end
         end
         if (gnt_any) begin
            wb_en_d   = 1'b1;
            wb_dest_d = dst_q[gnt_idx];
            wb_data_d = dat_q[gnt_idx];
            wb_sel_d  = gnt_idx;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         vld_q     <= '0;
         wb_en_q   <= 1'b0;
         wb_dest_q <= '0;
         wb_data_q <= '0;
         wb_sel_q  <= SRC_ALU;
         for (int n = 0; n < NUM_SRC; n++) begin
            dat_q[n] <= '0;
            dst_q[n] <= '0;
         end
`ifdef WB_ROUND_ROBIN_EN
         ptr_q     <= SRC_ALU;
`endif
      end else begin
         vld_q     <= vld_d;
         dat_q     <= dat_d;
         dst_q     <= dst_d;
         wb_en_q   <= wb_en_d;
         wb_dest_q <= wb_dest_d;
         wb_data_q <= wb_data_d;
         wb_sel_q  <= wb_sel_d;
`ifdef WB_ROUND_ROBIN_EN
         ptr_q     <= ptr_d;
`endif
      end
   end

   assign wb_en   = wb_en_q;
   assign wb_dest = wb_dest_q;
   assign wb_data = wb_data_q;
   assign wb_sel  = wb_sel_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: reset, single transfer, contention,
// streaming, flush and reset mid-run, with hand-computed expectations.
module tb_wb_arbiter;

   localparam int DATA_W = 16;
   localparam int REG_W  = 3;

   logic              clock = 1'b0;
   logic              reset, flush;
   logic              s0_valid, s1_valid, s2_valid;
   logic [DATA_W-1:0] s0_data, s1_data, s2_data;
   logic [REG_W-1:0]  s0_dest, s1_dest, s2_dest;
   logic              s0_ready, s1_ready, s2_ready;
   logic              wb_en;
   logic [REG_W-1:0]  wb_dest;
   logic [DATA_W-1:0] wb_data;
   logic [1:0]        wb_sel;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clock = ~clock;

   wb_arbiter #(.DATA_W(DATA_W), .REG_W(REG_W)) dut (
      .clock    (clock),
      .reset    (reset),
      .flush    (flush),
      .s0_valid (s0_valid), .s0_data (s0_data), .s0_dest (s0_dest), .s0_ready (s0_ready),
      .s1_valid (s1_valid), .s1_data (s1_data), .s1_dest (s1_dest), .s1_ready (s1_ready),
      .s2_valid (s2_valid), .s2_data (s2_data), .s2_dest (s2_dest), .s2_ready (s2_ready),
      .wb_en    (wb_en),
      .wb_dest  (wb_dest),
      .wb_data  (wb_data),
      .wb_sel   (wb_sel)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance one edge and settle away from it.
   task automatic step();
      @(posedge clock);
      #2;
   endtask

   function automatic logic [31:0] rdy3();
      return {29'd0, s2_ready, s1_ready, s0_ready};
   endfunction

   task automatic idle_inputs();
      flush    = 1'b0;
      s0_valid = 1'b0; s1_valid = 1'b0; s2_valid = 1'b0;
      s0_data  = '0;   s1_data  = '0;   s2_data  = '0;
      s0_dest  = '0;   s1_dest  = '0;   s2_dest  = '0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      reset = 1'b0;
      #1;
   endtask

   initial begin
      reset = 1'b1;
      idle_inputs();

      // Reset state.
      step();
      #1;
      check_eq("rst_ready", rdy3(), 32'h0);
      check_eq("rst_wb_en", wb_en, 0);
      check_eq("rst_wb_dest", wb_dest, 0);
      check_eq("rst_wb_data", wb_data, 0);
      check_eq("rst_wb_sel", wb_sel, 0);
      reset = 1'b0;
      #1;
      check_eq("post_rst_ready", rdy3(), 32'h7);

      // Single transfer from s0.
      s0_valid = 1'b1; s0_data = 16'h1234; s0_dest = 3'd5;
      step();
      s0_valid = 1'b0;
      check_eq("single_lat_en", wb_en, 0);
      step();
      check_eq("single_en", wb_en, 1);
      check_eq("single_dest", wb_dest, 5);
      check_eq("single_data", wb_data, 32'h1234);
      check_eq("single_sel", wb_sel, 0);
      step();
      check_eq("single_idle_en", wb_en, 0);
      check_eq("single_hold_dest", wb_dest, 5);

      // Contention, all three captured on the same edge.
      do_reset();
      s0_valid = 1'b1; s0_data = 16'h00A0; s0_dest = 3'd1;
      s1_valid = 1'b1; s1_data = 16'h00B0; s1_dest = 3'd2;
      s2_valid = 1'b1; s2_data = 16'h00C0; s2_dest = 3'd3;
      step();
`ifdef WB_ROUND_ROBIN_EN
      begin
         logic [15:0] exp_dat [3];
         exp_dat[0] = 16'h00A0; exp_dat[1] = 16'h00B0; exp_dat[2] = 16'h00C0;
         for (int i = 0; i < 9; i++) begin
            if (i == 5) begin
               s0_valid = 1'b0; s1_valid = 1'b0; s2_valid = 1'b0;
            end
            step();
            if (i < 8) begin
               check_eq($sformatf("rr_en_%0d", i), wb_en, 1);
               check_eq($sformatf("rr_sel_%0d", i), wb_sel, i % 3);
               check_eq($sformatf("rr_data_%0d", i), wb_data, exp_dat[i % 3]);
            end else begin
               check_eq("rr_drained_en", wb_en, 0);
            end
         end
      end
`else
      s0_valid = 1'b0; s1_valid = 1'b0; s2_valid = 1'b0;
      check_eq("fp_ready_0", rdy3(), 32'h4);
      step();
      check_eq("fp_en_0", wb_en, 1);
      check_eq("fp_sel_0", wb_sel, 2);
      check_eq("fp_data_0", wb_data, 32'hC0);
      check_eq("fp_dest_0", wb_dest, 3);
      check_eq("fp_ready_1", rdy3(), 32'h5);
      step();
      check_eq("fp_en_1", wb_en, 1);
      check_eq("fp_sel_1", wb_sel, 0);
      check_eq("fp_data_1", wb_data, 32'hA0);
      check_eq("fp_ready_2", rdy3(), 32'h7);
      step();
      check_eq("fp_en_2", wb_en, 1);
      check_eq("fp_sel_2", wb_sel, 1);
      check_eq("fp_data_2", wb_data, 32'hB0);
      check_eq("fp_dest_2", wb_dest, 2);
      step();
      check_eq("fp_idle_en", wb_en, 0);
`endif

      // Streaming from s1.
      for (int i = 0; i < 9; i++) begin
         if (i < 8) begin
            s1_valid = 1'b1;
            s1_data  = 16'h0100 + 16'(i);
            s1_dest  = 3'd4;
         end else begin
            s1_valid = 1'b0;
         end
         step();
         check_eq($sformatf("stream_ready_%0d", i), s1_ready, 1);
         if (i >= 1) begin
            check_eq($sformatf("stream_en_%0d", i), wb_en, 1);
            check_eq($sformatf("stream_data_%0d", i), wb_data, 32'h0100 + 32'(i - 1));
         end
      end
      step();
      check_eq("stream_tail_en", wb_en, 0);

      // Flush with s0 and s2 pending and s1 presenting.
      s0_valid = 1'b1; s0_data = 16'h0011; s0_dest = 3'd6;
      s2_valid = 1'b1; s2_data = 16'h0022; s2_dest = 3'd7;
      step();
      s0_valid = 1'b0; s2_valid = 1'b0;
      flush = 1'b1;
      s1_valid = 1'b1; s1_data = 16'h0033; s1_dest = 3'd1;
      #1;
      check_eq("flush_ready_low", rdy3(), 32'h0);
      step();
      flush = 1'b0; s1_valid = 1'b0;
      #1;
      check_eq("flush_en", wb_en, 0);
      check_eq("flush_hold_data", wb_data, 32'h0107);
      check_eq("flush_ready_after", rdy3(), 32'h7);
      step();
      check_eq("flush_no_capture_en", wb_en, 0);
      step();
      check_eq("flush_no_capture_en2", wb_en, 0);

      // Reset mid-run with two entries pending.
      s0_valid = 1'b1; s0_data = 16'h0055; s0_dest = 3'd2;
      s1_valid = 1'b1; s1_data = 16'h0066; s1_dest = 3'd6;
      step();
      s0_valid = 1'b0; s1_valid = 1'b0;
      reset = 1'b1;
      step();
      check_eq("mid_rst_en", wb_en, 0);
      check_eq("mid_rst_dest", wb_dest, 0);
      check_eq("mid_rst_data", wb_data, 0);
      check_eq("mid_rst_sel", wb_sel, 0);
      check_eq("mid_rst_ready", rdy3(), 32'h0);
      reset = 1'b0;
      #1;
      check_eq("mid_rst_ready_after", rdy3(), 32'h7);
      step();
      check_eq("mid_rst_no_wb_0", wb_en, 0);
      step();
      check_eq("mid_rst_no_wb_1", wb_en, 0);
      check_eq("mid_rst_data_zero", wb_data, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
